// File: rtl/uart_sample_rx.sv
// 8N1 UART receiver that rebuilds two-byte frames into 14-bit samples
// and queues them in a first-word-fall-through FIFO with rx_ready flow control.
module uart_sample_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 14,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              rx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_err,
    output logic              seq_err,
    output logic              overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW+1:0] READY_MAX = (AW + 2)'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        BS_IDLE,
        BS_START,
        BS_DATA,
        BS_STOP
    } bit_state_t;

    typedef enum logic {
        AS_LOW,
        AS_HIGH
    } asm_state_t;

    // Synchroniser, plus one extra stage for falling-edge detection.
    logic rxd_meta;
    logic rxd_s;
    logic rxd_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_s_q  <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_s_q  <= rxd_s;
        end
    end

    bit_state_t  bit_state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  byte_data;
    logic        byte_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_state  <= BS_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (bit_state)
                BS_IDLE: begin
                    if (rxd_s_q && !rxd_s) begin
                        bit_state <= BS_START;
                        bit_cnt   <= '0;
                    end
                end
                BS_START: begin
                    // A start bit that is high again at mid-bit is a glitch.
                    if (bit_cnt == HALF_M1) begin
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        bit_state <= rxd_s ? BS_IDLE : BS_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                BS_DATA: begin
                    if (bit_cnt == FULL_M1) begin
                        bit_cnt <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_state <= BS_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                BS_STOP: begin
                    // Leave at stop-bit centre so a back-to-back start edge is seen.
                    if (bit_cnt == FULL_M1) begin
                        bit_cnt   <= '0;
                        bit_state <= BS_IDLE;
                        if (rxd_s) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: bit_state <= BS_IDLE;
            endcase
        end
    end

    asm_state_t        asm_state;
    logic [6:0]        lo_bits;
    logic              push_req;
    logic [DATA_W-1:0] push_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_state <= AS_LOW;
            lo_bits   <= '0;
            push_req  <= 1'b0;
            push_data <= '0;
            seq_err   <= 1'b0;
        end else begin
            push_req <= 1'b0;
            seq_err  <= 1'b0;
            if (frame_err) begin
                asm_state <= AS_LOW;
            end else if (byte_valid) begin
                case (asm_state)
                    AS_LOW: begin
                        if (!byte_data[7]) begin
                            lo_bits   <= byte_data[6:0];
                            asm_state <= AS_HIGH;
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                    AS_HIGH: begin
                        // A second low byte replaces the first: resync on the newest one.
                        if (byte_data[7]) begin
                            push_req  <= 1'b1;
                            push_data <= {byte_data[6:0], lo_bits};
                            asm_state <= AS_LOW;
                        end else begin
                            seq_err <= 1'b1;
                            lo_bits <= byte_data[6:0];
                        end
                    end
                    default: asm_state <= AS_LOW;
                endcase
            end
        end
    end

    // dout handshake: dout is valid while dout_valid is high; an entry is
    // consumed on any clk edge where dout_valid && dout_ready are both high.
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       fifo_count;
    logic [AW+1:0]     next_count;
    logic              fifo_full;
    logic              pop;
    logic              push_ok;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == CNT_FULL);
    assign dout_valid = (fifo_count != '0);
    assign pop        = dout_valid && dout_ready;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign dout       = dout_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign next_count = {1'b0, fifo_count} + (AW + 2)'(push_ok) - (AW + 2)'(pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_ready <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            // Two free slots leave room for the frame already in flight.
            rx_ready <= (next_count <= READY_MAX);
        end
    end

endmodule
